// File: rtl/flt2fix_if.sv
// flt2fix_if: start/done handshake and operand/result bus of the float16 to 8.8 fixed-point converter.
interface flt2fix_if;
    logic        start;
    logic [15:0] flt_in;
    logic [15:0] fix_out;
    logic        done;
    logic        busy;
    logic        ovf;
    logic        inv;
    modport master (output start, flt_in, input fix_out, done, busy, ovf, inv);
    modport slave (input start, flt_in, output fix_out, done, busy, ovf, inv);
endinterface

// File: rtl/flt2fix_unit.sv
// flt2fix_unit: multi-cycle float16 to signed 8.8 fixed-point converter with a one-bit-per-cycle aligner.
// FLT2FIX_ROUND_EN selects round-to-nearest-even; otherwise the magnitude is truncated toward zero.
module flt2fix_unit (
    input logic       clk,
    input logic       rst,
    flt2fix_if.slave  bus
);
    localparam logic [2:0] IDLE = 3'd0, CLASS = 3'd1, SHIFT = 3'd2, ROUND = 3'd3, DONE = 3'd4;
`ifdef FLT2FIX_ROUND_EN
    localparam logic RND_EN = 1'b1;
`else
    localparam logic RND_EN = 1'b0;
`endif
    logic [2:0]  state_q, state_d;
    logic [15:0] op_q, mag_q, frc_q, fix_q;
    logic [3:0]  k_q;
    logic        left_q, g_q, st_q, frc_en_q, fovf_q, finv_q, ovf_q, inv_q;
    logic [4:0]  e, c_dist;
    logic [9:0]  m;
    logic [3:0]  c_k;
    logic [15:0] sat, c_val, rnd_mag, res;
    logic        c_force, c_nan, c_ovf, rnd;
    assign e       = op_q[14:10];
    assign m       = op_q[9:0];
    assign sat     = op_q[15] ? 16'h8000 : 16'h7FFF;
    // value*256 = {1,m} * 2^(e-17), so e=17 needs no alignment
    assign c_dist  = (e > 5'd17) ? e - 5'd17 : 5'd17 - e;
    assign c_force = (e <= 5'd5) || (e >= 5'd22);
    assign c_nan   = (e == 5'd31) && (m != 10'd0);
    assign c_ovf   = (e >= 5'd22) && !c_nan && (op_q != 16'hD800);
    assign c_val   = ((e >= 5'd22) && !c_nan) ? sat : 16'h0000;
    assign c_k     = c_force ? 4'd0 : c_dist[3:0];
    assign rnd     = RND_EN & g_q & (st_q | mag_q[0]);
    assign rnd_mag = mag_q + {15'd0, rnd};
    assign res     = frc_en_q ? frc_q : (op_q[15] ? -rnd_mag : rnd_mag);
    assign state_d = (state_q == IDLE || state_q == DONE) ? (bus.start ? CLASS : IDLE)
                   : (state_q == CLASS) ? ((c_k == 4'd0) ? ROUND : SHIFT)
                   : (state_q == SHIFT) ? ((k_q == 4'd1) ? ROUND : SHIFT)
                   : (state_q == ROUND) ? DONE : IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            mag_q    <= '0;
            frc_q    <= '0;
            fix_q    <= '0;
            k_q      <= '0;
            left_q   <= 1'b0;
            g_q      <= 1'b0;
            st_q     <= 1'b0;
            frc_en_q <= 1'b0;
            fovf_q   <= 1'b0;
            finv_q   <= 1'b0;
            ovf_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE, DONE: if (bus.start) op_q <= bus.flt_in;
                CLASS: begin
                    mag_q    <= {5'd0, 1'b1, m};
                    k_q      <= c_k;
                    left_q   <= e > 5'd17;
                    g_q      <= 1'b0;
                    st_q     <= 1'b0;
                    frc_en_q <= c_force;
                    frc_q    <= c_val;
                    fovf_q   <= c_ovf;
                    finv_q   <= c_nan;
                end
                SHIFT: begin
                    mag_q <= left_q ? mag_q << 1 : mag_q >> 1;
                    k_q   <= k_q - 4'd1;
                    if (!left_q) begin
                        g_q  <= mag_q[0];
                        st_q <= st_q | g_q;
                    end
                end
                ROUND: begin
                    fix_q <= res;
                    ovf_q <= fovf_q;
                    inv_q <= finv_q;
                end
                default: ;
            endcase
        end
    end
    assign bus.fix_out = fix_q;
    assign bus.ovf     = ovf_q;
    assign bus.inv     = inv_q;
    assign bus.done    = state_q == DONE;
    assign bus.busy    = (state_q == CLASS) || (state_q == SHIFT) || (state_q == ROUND);
endmodule

// File: tb/tb_flt2fix_unit.sv
// tb_flt2fix_unit: directed vectors, handshake/reset sequences and a fixed->float->fixed round trip.
module tb_flt2fix_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    flt2fix_if bus ();
    flt2fix_unit dut (.clk(clk), .rst(rst), .bus(bus));
    int errors = 0;
    int checks = 0;
    typedef struct {
        logic [15:0] flt;
        logic [15:0] fix;
        logic        ovf;
        logic        inv;
        int          lat;
    } vec_t;
    vec_t vt[$];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic run(input logic [15:0] f, output logic [15:0] r, output logic o, output logic iv, output int lat);
        bus.flt_in = f;
        bus.start  = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("done_seen", {31'd0, bus.done}, 32'd1);
        r  = bus.fix_out;
        o  = bus.ovf;
        iv = bus.inv;
        @(posedge clk);
        #1;
    endtask
    // exact fixed->float16 for magnitudes with at most 11 significant bits
    function automatic logic [15:0] to_flt(input logic [15:0] v);
        int p = 0;
        logic [15:0] mm;
        for (int i = 0; i < 16; i++) if (v[i]) p = i;
        mm = (p >= 10) ? v >> (p - 10) : v << (10 - p);
        return {1'b0, 5'(p + 7), mm[9:0]};
    endfunction
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [15:0] r, v, f, prev;
        logic o, iv, sg;
        int lat, pulses, changed, p;
        bus.start  = 1'b0;
        bus.flt_in = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fix", {16'd0, bus.fix_out}, 32'h0);
        chk("rst_done", {31'd0, bus.done}, 32'h0);
        chk("rst_busy", {31'd0, bus.busy}, 32'h0);
        chk("rst_ovf", {31'd0, bus.ovf}, 32'h0);
        chk("rst_inv", {31'd0, bus.inv}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        vt.push_back('{16'h3C00, 16'h0100, 1'b0, 1'b0, 4});
        vt.push_back('{16'hBC00, 16'hFF00, 1'b0, 1'b0, 4});
        vt.push_back('{16'h1C00, 16'h0001, 1'b0, 1'b0, 12});
`ifdef FLT2FIX_ROUND_EN
        vt.push_back('{16'h1E00, 16'h0002, 1'b0, 1'b0, 12});
        vt.push_back('{16'h1A00, 16'h0001, 1'b0, 1'b0, 13});
`else
        vt.push_back('{16'h1E00, 16'h0001, 1'b0, 1'b0, 12});
        vt.push_back('{16'h1A00, 16'h0000, 1'b0, 1'b0, 13});
`endif
        vt.push_back('{16'h1800, 16'h0000, 1'b0, 1'b0, 13});
        vt.push_back('{16'h1400, 16'h0000, 1'b0, 1'b0, 2});
        vt.push_back('{16'h57FF, 16'h7FF0, 1'b0, 1'b0, 6});
        vt.push_back('{16'h5BFF, 16'h7FFF, 1'b1, 1'b0, 2});
        vt.push_back('{16'hD800, 16'h8000, 1'b0, 1'b0, 2});
        vt.push_back('{16'hD801, 16'h8000, 1'b1, 1'b0, 2});
        vt.push_back('{16'h7C00, 16'h7FFF, 1'b1, 1'b0, 2});
        vt.push_back('{16'hFC00, 16'h8000, 1'b1, 1'b0, 2});
        vt.push_back('{16'h7E00, 16'h0000, 1'b0, 1'b1, 2});
        vt.push_back('{16'h0001, 16'h0000, 1'b0, 1'b0, 2});
        vt.push_back('{16'h4000, 16'h0200, 1'b0, 1'b0, 3});
        vt.push_back('{16'h4400, 16'h0400, 1'b0, 1'b0, 2});
        vt.push_back('{16'h3E00, 16'h0180, 1'b0, 1'b0, 4});
        vt.push_back('{16'h3C01, 16'h0100, 1'b0, 1'b0, 4});
        vt.push_back('{16'hC900, 16'hF600, 1'b0, 1'b0, 3});
        vt.push_back('{16'h3555, 16'h0055, 1'b0, 1'b0, 6});
        foreach (vt[i]) begin
            run(vt[i].flt, r, o, iv, lat);
            chk($sformatf("fix[%h]", vt[i].flt), {16'd0, r}, {16'd0, vt[i].fix});
            chk($sformatf("ovf[%h]", vt[i].flt), {31'd0, o}, {31'd0, vt[i].ovf});
            chk($sformatf("inv[%h]", vt[i].flt), {31'd0, iv}, {31'd0, vt[i].inv});
            chk($sformatf("lat[%h]", vt[i].flt), lat, vt[i].lat);
        end
        // start held high through busy; operand changes while busy must not matter
        run(16'h4000, r, o, iv, lat);
        prev = bus.fix_out;
        bus.flt_in = 16'h3C00;
        bus.start  = 1'b1;
        pulses  = 0;
        changed = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            bus.flt_in = 16'hBC00;
            if (bus.busy && bus.fix_out !== prev) changed++;
            if (bus.done) begin
                pulses++;
                chk("held_fix", {16'd0, bus.fix_out}, 32'h0100);
                bus.start = 1'b0;
            end
        end
        chk("held_pulses", pulses, 1);
        chk("held_nochange", changed, 0);
        // new start accepted in the DONE cycle
        bus.flt_in = 16'h3C00;
        bus.start  = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("dc_first", {16'd0, bus.fix_out}, 32'h0100);
        run(16'hBC00, r, o, iv, lat);
        chk("dc_second", {16'd0, r}, 32'hFF00);
        chk("dc_lat", lat, 4);
        // asynchronous reset during SHIFT
        bus.flt_in = 16'h1C00;
        bus.start  = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_busy", {31'd0, bus.busy}, 32'h1);
        rst = 1'b1;
        #1;
        chk("ar_fix", {16'd0, bus.fix_out}, 32'h0);
        chk("ar_busy", {31'd0, bus.busy}, 32'h0);
        chk("ar_done", {31'd0, bus.done}, 32'h0);
        chk("ar_ovf", {31'd0, bus.ovf}, 32'h0);
        chk("ar_inv", {31'd0, bus.inv}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        pulses = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) pulses++;
        end
        chk("ar_quiet", pulses, 0);
        run(16'h4000, r, o, iv, lat);
        chk("ar_next", {16'd0, r}, 32'h0200);
        chk("ar_next_lat", lat, 3);
        // round trip through an exact fixed->float model
        for (int n = 0; n < 48; n++) begin
            v = 16'($urandom_range(1, 16'h7FFF));
            p = 0;
            for (int i = 0; i < 16; i++) if (v[i]) p = i;
            if (p > 10) v = v & (16'hFFFF << (p - 10));
            sg = 1'($urandom_range(0, 1));
            f = to_flt(v) | {sg, 15'd0};
            run(f, r, o, iv, lat);
            chk($sformatf("rt[%h]", f), {16'd0, r}, {16'd0, sg ? -v : v});
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
